reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Sequencing controller that shares one pulse-enabled 32-bit register among N requesters. Requesters raise `req` with write data. The arbiter picks one winner, drives the register's data input, and fires a single-cycle write-enable pulse (the `en` input of the enable-triggered `register` block). It then returns a one-cycle grant acknowledge. It replaces the free-running clock-derived pulse generator wherever more than one source must write the same register.

## Interface
- `N`, 4, number of requesters (2..8)
- `W`, 32, data width
- `clk`  in  1  system clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous reset, active-low
- `req`  in  N  write request per requester; held high with data stable until its `gnt`
- `wdata`  in  N*W  write data; requester i on bits [i*W +: W]
- `gnt`  out  N  one-hot acknowledge, high exactly one cycle after the write pulse
- `reg_en`  out  1  single-cycle write-enable pulse to the register
- `reg_d`  out  W  data presented to the register
- `busy`  out  1  high in any state other than IDLE
- `last_id`  out  $clog2(N)  index of the most recently written requester

## Operation
- FSM states: IDLE, SEL, WRITE, ACK.
- IDLE: if any `req` bit is high, go to SEL. Latch the winner index and `reg_d <= wdata[winner]` on that edge. Otherwise stay in IDLE.
- SEL -> WRITE unconditionally; `reg_en` goes high for the WRITE cycle only.
- WRITE -> ACK unconditionally; `gnt[winner]` goes high for the ACK cycle only. `last_id <= winner`.
- ACK -> IDLE unconditionally.
- A write is committed once SEL is entered. Dropping `req` during SEL, WRITE or ACK does not cancel the pulse or the grant.
- The requester must deassert `req` in the cycle after `gnt`. A `req` still high in IDLE is treated as a new request.
- `reg_d` holds its value from SEL until the next SEL. It is not cleared in IDLE.
- All outputs are registered. There is no combinational path from `req` or `wdata` to any output.
- Requests arriving while `busy` is high wait. Nothing is dropped and nothing is queued beyond the `req` level.

## Timing
- Reset values: state IDLE, `gnt`=0, `reg_en`=0, `reg_d`=0, `busy`=0, `last_id`=0, round-robin pointer 0.
- Suppose `req` is high before edge k while in IDLE:
  - SEL from k
  - `reg_en`=1 between edges k+1 and k+2
  - `gnt`=1 between edges k+2 and k+3
  - IDLE at k+3
- Latency from `req` to `reg_en` is 1 cycle of SEL after the sampling edge. Maximum throughput is one write per 4 cycles.
- `reg_en` is never high for two consecutive cycles. `gnt` is never high in the same cycle as `reg_en`.
- Asserting `rst_n` low mid-operation forces the reset values immediately (asynchronous). No pulse or grant is emitted for the aborted transfer. After release the FSM starts in IDLE.
- With `req` all zero, the block stays in IDLE indefinitely with outputs stable.

## Configuration
- `REG_WRITE_ARB_RR_EN`:
  - Defined: round-robin arbitration. After granting requester i, priority search starts at (i+1) mod N. The pointer updates on entry to SEL.
  - Undefined: fixed priority, lowest index wins. The pointer logic is absent, and a continuously requesting requester 0 starves all others.

## Structure
- Shared package `reg_arb_pkg`:
  - state enum (IDLE, SEL, WRITE, ACK)
  - default `N` and `W` constants
  - index-width helper constant
- One sub-module `rr_pick`, combinational: inputs are the `req` vector and the pointer; outputs are the winner index and a valid flag. Under fixed priority, the pointer is tied to 0.

## Test plan
- Reset with `req`=0 -> all outputs 0. Release reset with no requests -> `busy` stays 0 for 20 cycles.
- Single request: `req`=4'b0100, `wdata[2]`=32'h0000_0003 -> `reg_en` pulses once with `reg_d`=3, `gnt`=4'b0100 on the next cycle, `last_id`=2, then IDLE.
- Simultaneous `req`=4'b1111, data 10/11/12/13, each requester drops `req` after its `gnt`:
  - with RR_EN: grants in order 0,1,2,3 and `reg_d` sequence 10,11,12,13
  - without RR_EN: the same order, because each drops
- Starvation check: `req`=4'b0011 with requester 0 re-raising `req` immediately after its `gnt`:
  - with RR_EN: grants alternate 0,1,0,1
  - without RR_EN: requester 0 only
- `req` dropped in the SEL cycle -> `reg_en` and `gnt` still occur for that requester with the latched data.
- `rst_n` pulsed low during WRITE -> `reg_en` drops in the same cycle, no `gnt` is issued, and after release a pending `req` is re-arbitrated from pointer 0.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register write arbiter.
package reg_arb_pkg;

  localparam int unsigned DEF_N  = 4;
  localparam int unsigned DEF_W  = 32;
  localparam int unsigned DEF_IW = $clog2(DEF_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEL   = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational priority pick: first asserted request at or after ptr, wrapping.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  parameter int unsigned IW = idx_w(DEF_N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int unsigned j;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!valid && req[IW'(j)]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares one pulse-enabled register among N requesters: pick, write pulse, grant.
// Define REG_WRITE_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [N*W-1:0]         wdata,
  output logic [N-1:0]           gnt,
  output logic                   reg_en,
  output logic [W-1:0]           reg_d,
  output logic                   busy,
  output logic [idx_w(N)-1:0]    last_id
);

  localparam int unsigned IW = idx_w(N);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] win_q, win_d;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [IW-1:0] ptr;
  logic [N-1:0]  gnt_d;
  logic          reg_en_d;
  logic [W-1:0]  reg_d_d;
  logic          busy_d;
  logic [IW-1:0] last_id_d;

`ifdef REG_WRITE_ARB_RR_EN
  logic [IW-1:0] ptr_d;
`else
  assign ptr = '0;
`endif

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    gnt_d     = '0;
    reg_en_d  = 1'b0;
    reg_d_d   = reg_d;
    last_id_d = last_id;
`ifdef REG_WRITE_ARB_RR_EN
    ptr_d     = ptr;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = SEL;
          win_d   = pick_idx;
          reg_d_d = wdata[32'(pick_idx)*W +: W];
`ifdef REG_WRITE_ARB_RR_EN
          ptr_d   = IW'((32'(pick_idx) + 1) % N);
`endif
        end
      end
      SEL: begin
        state_d  = WRITE;
        reg_en_d = 1'b1;
      end
      WRITE: begin
        state_d   = ACK;
        gnt_d     = N'(1) << win_q;
        last_id_d = win_q;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      gnt     <= '0;
      reg_en  <= 1'b0;
      reg_d   <= '0;
      busy    <= 1'b0;
      last_id <= '0;
`ifdef REG_WRITE_ARB_RR_EN
      ptr     <= '0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      gnt     <= gnt_d;
      reg_en  <= reg_en_d;
      reg_d   <= reg_d_d;
      busy    <= busy_d;
      last_id <= last_id_d;
`ifdef REG_WRITE_ARB_RR_EN
      ptr     <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter against a transaction-level model.
module tb_reg_write_arbiter;
  import reg_arb_pkg::*;

  localparam int unsigned N  = DEF_N;
  localparam int unsigned W  = DEF_W;
  localparam int unsigned IW = idx_w(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic           reg_en;
  logic [W-1:0]   reg_d;
  logic           busy;
  logic [IW-1:0]  last_id;

  reg_write_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .reg_en  (reg_en),
    .reg_d   (reg_d),
    .busy    (busy),
    .last_id (last_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: cycles elapsed since the transfer was committed (0 = idle).
  int           m_age;
  int           m_win;
  int           m_last;
  int           m_ptr;
  logic [W-1:0] m_data;
  int           gq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < int'(N); k++)
      if (r[(p + k) % int'(N)]) return (p + k) % int'(N);
    return -1;
  endfunction

  task automatic model_reset();
    m_age  = 0;
    m_win  = 0;
    m_last = 0;
    m_ptr  = 0;
    m_data = '0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    int w;
    if (m_age == 0) begin
`ifdef REG_WRITE_ARB_RR_EN
      w = pick(req, m_ptr);
`else
      w = pick(req, 0);
`endif
      if (w >= 0) begin
        m_win  = w;
        m_data = wdata[w*W +: W];
        m_ptr  = (w + 1) % int'(N);
        m_age  = 1;
      end
    end else begin
      m_age = (m_age + 1) % 4;
      if (m_age == 3) m_last = m_win;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] eg;
    eg = (m_age == 3) ? (N'(1) << m_win) : '0;
    check("reg_en",  64'(reg_en),  64'(m_age == 2));
    check("gnt",     64'(gnt),     64'(eg));
    check("busy",    64'(busy),    64'(m_age != 0));
    check("reg_d",   64'(reg_d),   64'(m_data));
    check("last_id", 64'(last_id), 64'(m_last));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    for (int i = 0; i < int'(N); i++)
      if (gnt[i]) gq.push_back(i);
  endtask

  // Run n cycles; requesters drop req during their grant unless kept in keep.
  task automatic run(input int n, input logic [N-1:0] keep);
    repeat (n) begin
      step();
      if (m_age == 3 && !keep[m_win]) req[m_win] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    gq.delete();
  endtask

  task automatic check_grants(input string tag, input int exp[4]);
    check({tag, "_count"}, 64'(gq.size() >= 4), 64'(1));
    for (int i = 0; i < 4; i++)
      check(tag, (i < gq.size()) ? 64'(gq[i]) : 64'hdead, 64'(exp[i]));
  endtask

  initial begin
    int exp_g[4];
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    run(20, '0);

    // Single request from requester 2.
    wdata[2*W +: W] = 32'h0000_0003;
    req = 4'b0100;
    gq.delete();
    run(6, '0);
    check("single_count", 64'(gq.size()), 64'(1));
    if (gq.size() > 0) check("single_id", 64'(gq[0]), 64'(2));
    check("single_last", 64'(last_id), 64'(2));
    check("single_d", 64'(reg_d), 64'(3));

    // All four request together, each drops after its grant.
    apply_reset();
    for (int i = 0; i < int'(N); i++) wdata[i*W +: W] = W'(10 + i);
    req = 4'b1111;
    run(18, '0);
    exp_g = '{0, 1, 2, 3};
    check_grants("simul_order", exp_g);

    // Both requesters re-raise immediately after each grant.
    apply_reset();
    req = 4'b0011;
    run(16, 4'b0011);
`ifdef REG_WRITE_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    check_grants("starve", exp_g);
    req = '0;
    run(4, '0);

    // Request dropped during SEL still completes with latched data.
    apply_reset();
    wdata[3*W +: W] = 32'hdead_beef;
    req = 4'b1000;
    step();
    req = '0;
    wdata[3*W +: W] = 32'h1234_5678;
    run(5, '0);
    check("drop_count", 64'(gq.size()), 64'(1));
    if (gq.size() > 0) check("drop_id", 64'(gq[0]), 64'(3));
    check("drop_d", 64'(reg_d), 64'(32'hdead_beef));

    // Asynchronous reset in the WRITE cycle; pending request restarts from pointer 0.
    apply_reset();
    req = 4'b0110;
    step();
    step();
    check("pre_rst_en", 64'(reg_en), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_en", 64'(reg_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_gnt", 64'(gnt), 64'(0));
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    gq.delete();
    run(3, '0);
    check("rearb_count", 64'(gq.size()), 64'(1));
    if (gq.size() > 0) check("rearb_id", 64'(gq[0]), 64'(1));
    req = '0;
    run(4, '0);

    // Random traffic with random re-raise after grant.
    apply_reset();
    repeat (3000) begin
      step();
      for (int i = 0; i < int'(N); i++) begin
        if (m_age == 3 && m_win == i) begin
          req[i] = ($urandom_range(3) == 0);
        end else if (!req[i] && $urandom_range(2) == 0) begin
          req[i] = 1'b1;
          wdata[i*W +: W] = $urandom;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
